// File: rtl/display_pkg.sv
// Shared types and constants for the segment display arbiter.
package display_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    localparam logic [1:0] DIG_LO  = 2'b01;
    localparam logic [1:0] DIG_HI  = 2'b10;
    localparam int         MAX_REQ = 8;

endpackage

// File: rtl/seg_display_arbiter_rr_picker.sv
// Combinational round-robin picker: the search starts just after the last
// winner and wraps, so every active requester is served in turn.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] win,
    output logic               any
);

    // First active request at or after last+1 (modulo NUM_REQ) wins.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        any   = |req;
        found = 1'b0;
        idx   = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(last) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Shares a two-digit hex 7-segment display between NUM_REQ requesters:
// round-robin grant, minimum hold per granted byte, and digit scanning
// onto one shared segment bus. The hex decoder sits outside this block.
module seg_display_arbiter
    import display_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SCAN_DIV    = 50_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic [7:0]             byte_out,
    input  logic [13:0]            seg_in,
    output logic [6:0]             seg_out,
    output logic [1:0]             digit_sel
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  LAST_RST  = IDX_W'(NUM_REQ - 1);

    state_t              state_q,    state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]    last_q,     last_d;
    logic [7:0]          byte_q,     byte_d;
    logic [NUM_REQ-1:0]  grant_q,    grant_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic                digit_idx_q, digit_idx_d;
    logic [6:0]          seg_q,      seg_d;

    logic [NUM_REQ-1:0]  win;
    logic                any_req;
    logic [IDX_W-1:0]    win_idx;
    logic [7:0]          win_byte;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req  (req),
        .last (last_q),
        .win  (win),
        .any  (any_req)
    );

    // Encode the one-hot winner and select its data byte.
    always_comb begin
        win_idx  = '0;
        win_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) begin
                win_idx  = IDX_W'(i);
                win_byte = req_data[8*i +: 8];
            end
        end
    end

    // Arbitration FSM: grant from IDLE, or back-to-back when a hold expires.
    always_comb begin
        logic take;
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        byte_d     = byte_q;
        grant_d    = '0;
        take       = 1'b0;
        case (state_q)
            IDLE: begin
                take = any_req;
            end
            SHOW: begin
                if (hold_cnt_q == '0) begin
                    take = any_req;
                    if (!any_req) begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (take) begin
            state_d    = SHOW;
            hold_cnt_d = HOLD_LOAD;
            last_d     = win_idx;
            byte_d     = win_byte;
            grant_d    = win;
        end
    end

    // Free-running digit scan; segment register follows the new digit index
    // so seg_out and digit_sel always describe the same digit.
    always_comb begin
        logic wrap;
        wrap        = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = wrap ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q ^ wrap;
        seg_d       = digit_idx_d ? seg_in[13:7] : seg_in[6:0];
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last_q      <= LAST_RST;
            byte_q      <= 8'h00;
            grant_q     <= '0;
            scan_cnt_q  <= '0;
            digit_idx_q <= 1'b0;
            seg_q       <= 7'b0000000;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            byte_q      <= byte_d;
            grant_q     <= grant_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            seg_q       <= seg_d;
        end
    end

    assign grant     = grant_q;
    assign busy      = (state_q == SHOW);
    assign byte_out  = byte_q;
    assign seg_out   = seg_q;
    assign digit_sel = digit_idx_q ? DIG_HI : DIG_LO;

endmodule
